// File: rtl/sw_digit_capture.sv
// Switch front-end for the password lock: synchronise, debounce and turn the
// ten digit switches into one-cycle digit / multi-switch-error events.
module sw_digit_capture #(
    parameter int unsigned DEB_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] sw,
    output logic       digit_valid,
    output logic [3:0] digit,
    output logic       multi_err,
    output logic       held,
    output logic [9:0] sw_db
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic {
        HELD  = 1'b0,
        ARMED = 1'b1
    } state_t;

    logic [9:0]       s1_q, s1_d;
    logic [9:0]       s2_q, s2_d;
    logic [9:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       sw_db_q, sw_db_d;
    logic             db_ok_q, db_ok_d;
    state_t           state_q, state_d;
    logic             digit_valid_q, digit_valid_d;
    logic [3:0]       digit_q, digit_d;
    logic             multi_err_q, multi_err_d;
    logic             held_q, held_d;

    function automatic logic is_one_hot(input logic [9:0] v);
        return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
    endfunction

    function automatic logic [3:0] one_hot_index(input logic [9:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (v[k]) begin
                idx = 4'(k);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Synchroniser and shared-counter debounce. db_ok marks that sw_db holds a
    // genuinely settled value; the all-zero reset value of sw_db must not arm
    // the FSM, otherwise switches already up at reset would register a digit.
    always_comb begin
        s1_d    = sw;
        s2_d    = s1_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        sw_db_d = sw_db_q;
        db_ok_d = db_ok_q;
        if (s2_q != last_q) begin
            last_d = s2_q;
            cnt_d  = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_MAX) begin
            sw_db_d = last_q;
            db_ok_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Next-state logic: arm on full release, re-hold on any press.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HELD: begin
                if (db_ok_q && (sw_db_q == 10'd0)) begin
                    state_d = ARMED;
                end else begin
                    state_d = HELD;
                end
            end
            ARMED: begin
                if (sw_db_q != 10'd0) begin
                    state_d = HELD;
                end else begin
                    state_d = ARMED;
                end
            end
            default: state_d = HELD;
        endcase
    end

    // Output decode, registered below so every output comes straight from a flop.
    always_comb begin
        digit_valid_d = 1'b0;
        multi_err_d   = 1'b0;
        digit_d       = digit_q;
        held_d        = (state_d == HELD);
        if ((state_q == ARMED) && (sw_db_q != 10'd0)) begin
            if (is_one_hot(sw_db_q)) begin
                digit_valid_d = 1'b1;
                digit_d       = one_hot_index(sw_db_q);
            end else begin
                multi_err_d = 1'b1;
            end
        end else begin
            digit_valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q          <= 10'd0;
            s2_q          <= 10'd0;
            last_q        <= 10'd0;
            cnt_q         <= {CNT_W{1'b0}};
            sw_db_q       <= 10'd0;
            db_ok_q       <= 1'b0;
            state_q       <= HELD;
            digit_valid_q <= 1'b0;
            digit_q       <= 4'd0;
            multi_err_q   <= 1'b0;
            held_q        <= 1'b1;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            sw_db_q       <= sw_db_d;
            db_ok_q       <= db_ok_d;
            state_q       <= state_d;
            digit_valid_q <= digit_valid_d;
            digit_q       <= digit_d;
            multi_err_q   <= multi_err_d;
            held_q        <= held_d;
        end
    end

    assign digit_valid = digit_valid_q;
    assign digit       = digit_q;
    assign multi_err   = multi_err_q;
    assign held        = held_q;
    assign sw_db       = sw_db_q;

endmodule

// File: tb/tb_sw_digit_capture.sv
// Directed bench for sw_digit_capture with DEB_CYCLES=4: a table of switch
// patterns with hand-computed pulse counts, plus reset sequences.
module tb_sw_digit_capture;

    logic       clk;
    logic       rst;
    logic [9:0] sw;
    logic       digit_valid;
    logic [3:0] digit;
    logic       multi_err;
    logic       held;
    logic [9:0] sw_db;

    int n_checks = 0;
    int n_pass   = 0;
    int n_viol   = 0;
    logic prev_pulse = 1'b0;

    sw_digit_capture #(.DEB_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .digit_valid(digit_valid),
        .digit      (digit),
        .multi_err  (multi_err),
        .held       (held),
        .sw_db      (sw_db)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic [9:0] sw;
        int         cycles;
        int         exp_valid;
        int         exp_err;
        logic [3:0] exp_digit;
        logic       exp_held;
        logic [9:0] exp_swdb;
        int         exp_first;   // loop index of first pulse, 0 = no check
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(logic [9:0] s, int c, int v, int e, logic [3:0] d,
                                logic h, logic [9:0] db, int f);
        vec_t r;
        r.sw = s; r.cycles = c; r.exp_valid = v; r.exp_err = e;
        r.exp_digit = d; r.exp_held = h; r.exp_swdb = db; r.exp_first = f;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Holds sw for n cycles, sampling 1 ns after each rising edge.
    task automatic run_vec(input logic [9:0] s, input int n,
                           output int nv, output int ne, output int first);
        nv = 0; ne = 0; first = 0;
        sw = s;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (digit_valid && multi_err) n_viol++;
            if ((digit_valid || multi_err) && prev_pulse) n_viol++;
            prev_pulse = digit_valid || multi_err;
            if (digit_valid) nv++;
            if (multi_err) ne++;
            if ((digit_valid || multi_err) && first == 0) first = i;
        end
    endtask

    initial begin
        int nv, ne, first;

        vecs[0]  = mk(10'h001, 12, 1, 0, 4'd0, 1'b1, 10'h001, 8);
        vecs[1]  = mk(10'h000, 12, 0, 0, 4'd0, 1'b0, 10'h000, 0);
        vecs[2]  = mk(10'h008, 12, 1, 0, 4'd3, 1'b1, 10'h008, 8);
        vecs[3]  = mk(10'h000, 12, 0, 0, 4'd3, 1'b0, 10'h000, 0);
        vecs[4]  = mk(10'h004,  2, 0, 0, 4'd3, 1'b0, 10'h000, 0);
        vecs[5]  = mk(10'h000, 12, 0, 0, 4'd3, 1'b0, 10'h000, 0);
        vecs[6]  = mk(10'h011, 10, 0, 1, 4'd3, 1'b1, 10'h011, 8);
        vecs[7]  = mk(10'h000, 12, 0, 0, 4'd3, 1'b0, 10'h000, 0);
        vecs[8]  = mk(10'h200, 12, 1, 0, 4'd9, 1'b1, 10'h200, 8);
        vecs[9]  = mk(10'h000, 12, 0, 0, 4'd9, 1'b0, 10'h000, 0);
        vecs[10] = mk(10'h002, 40, 1, 0, 4'd1, 1'b1, 10'h002, 8);
        vecs[11] = mk(10'h022, 20, 0, 0, 4'd1, 1'b1, 10'h022, 0);
        vecs[12] = mk(10'h000, 12, 0, 0, 4'd1, 1'b0, 10'h000, 0);
        vecs[13] = mk(10'h020, 12, 1, 0, 4'd5, 1'b1, 10'h020, 8);
        vecs[14] = mk(10'h000, 12, 0, 0, 4'd5, 1'b0, 10'h000, 0);
        vecs[15] = mk(10'h001,  2, 0, 0, 4'd5, 1'b0, 10'h000, 0);
        vecs[16] = mk(10'h011, 12, 0, 1, 4'd5, 1'b1, 10'h011, 8);
        vecs[17] = mk(10'h000, 12, 0, 0, 4'd5, 1'b0, 10'h000, 0);

        // Reset for two cycles, then all switches off.
        rst = 1'b0;
        sw  = 10'h000;
        run_vec(10'h000, 2, nv, ne, first);
        check("reset_valid", int'(digit_valid), 0);
        check("reset_err", int'(multi_err), 0);
        check("reset_digit", int'(digit), 0);
        check("reset_swdb", int'(sw_db), 0);
        check("reset_held", int'(held), 1);
        rst = 1'b1;
        run_vec(10'h000, 8, nv, ne, first);
        check("idle_held", int'(held), 0);
        check("idle_pulses", nv + ne, 0);

        for (int k = 0; k < 18; k++) begin
            run_vec(vecs[k].sw, vecs[k].cycles, nv, ne, first);
            check($sformatf("v%0d_valid_cnt", k), nv, vecs[k].exp_valid);
            check($sformatf("v%0d_err_cnt", k), ne, vecs[k].exp_err);
            check($sformatf("v%0d_digit", k), int'(digit), int'(vecs[k].exp_digit));
            check($sformatf("v%0d_held", k), int'(held), int'(vecs[k].exp_held));
            check($sformatf("v%0d_swdb", k), int'(sw_db), int'(vecs[k].exp_swdb));
            if (vecs[k].exp_first != 0) begin
                check($sformatf("v%0d_latency", k), first, vecs[k].exp_first);
            end
        end

        // Reset in the middle of a debounce, switch still up afterwards.
        run_vec(10'h040, 3, nv, ne, first);
        check("midrst_pre_pulses", nv + ne, 0);
        rst = 1'b0;
        run_vec(10'h040, 2, nv, ne, first);
        check("midrst_in_reset_digit", int'(digit), 0);
        check("midrst_in_reset_held", int'(held), 1);
        rst = 1'b1;
        run_vec(10'h040, 20, nv, ne, first);
        check("midrst_post_pulses", nv + ne, 0);
        check("midrst_post_held", int'(held), 1);
        check("midrst_post_swdb", int'(sw_db), 'h040);
        run_vec(10'h000, 12, nv, ne, first);
        check("midrst_release_pulses", nv + ne, 0);
        check("midrst_release_held", int'(held), 0);
        run_vec(10'h040, 12, nv, ne, first);
        check("midrst_repress_valid", nv, 1);
        check("midrst_repress_digit", int'(digit), 6);
        check("midrst_repress_latency", first, 8);

        check("pulse_rules", n_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
